// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive deserializer.
// FSM states, line states, error codes and the SYNC pattern.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    EOP_WAIT = 2'd2
  } state_t;

  // {dp, dm}
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_STUFF  = 2'b01;
  localparam logic [1:0] ERR_ALIGN  = 2'b10;
  localparam logic [1:0] ERR_BABBLE = 2'b11;

  // window shifts in at the MSB: seven 0s then a 1
  localparam logic [7:0] SYNC_PAT = 8'h80;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// Line decode, NRZI decode and stuffed-bit removal.
// Ports: bit_en/dp/dm in, in_pkt enables unstuffing; bit_vld/bit_val/se0/stuff_err out.
module usb_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_en,
  input  logic dp,
  input  logic dm,
  input  logic in_pkt,
  output logic bit_vld,
  output logic bit_val,
  output logic se0,
  output logic stuff_err
);

  localparam int OCW = $clog2(STUFF_LEN + 1);

  logic [1:0]     ls;
  logic           line_se0;
  logic           cur_j;
  logic           prev_j;
  logic           dec;
  logic           stuffed;
  logic [OCW-1:0] ones;

  assign ls       = {dp, dm};
  assign line_se0 = (ls == LS_SE0) || (ls == LS_SE1);
  assign cur_j    = (ls == LS_J);
  assign dec      = (cur_j == prev_j);
  // the bit after a full run of ones is the stuffed one
  assign stuffed  = in_pkt && (ones == OCW'(STUFF_LEN));

  assign se0       = bit_en && line_se0;
  assign bit_vld   = bit_en && !line_se0 && !stuffed;
  assign bit_val   = dec;
  assign stuff_err = bit_en && !line_se0 && stuffed && dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_j <= 1'b1;
      ones   <= '0;
    end else begin
      // SE0 is followed by J, so history restarts at J
      if (bit_en) prev_j <= line_se0 ? 1'b1 : cur_j;
      if (!in_pkt) begin
        ones <= '0;
      end else if (bit_en && !line_se0) begin
        if (stuffed || !dec) ones <= '0;
        else ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_deser.sv
// USB receive byte deserializer: SYNC, byte assembly, EOP, errors, output stage.
// Optional USB_RX_ERR_CNT_EN enables the saturating rx_err_cnt counter.
module usb_rx_deser
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int MAX_BYTES    = 1028
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bit_en,
  input  logic       rx_dp,
  input  logic       rx_dm,
  output logic       rx_lp_sop,
  output logic       rx_lp_eop,
  output logic       rx_lp_valid,
  input  logic       rx_lp_ready,
  output logic [7:0] rx_lp_data,
  output logic       rx_active,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic [7:0] rx_err_cnt
);

  localparam int BCW = $clog2(MAX_BYTES + 2);
  localparam int SCW = $clog2(EOP_SE0_BITS + 1);

  logic bit_vld, bit_val, se0, stuff_err;

  state_t         state, state_n;
  logic [7:0]     win, win_n;
  logic [7:0]     sr, sr_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [BCW-1:0] byte_cnt, byte_cnt_n;
  logic [SCW-1:0] se0_cnt, se0_cnt_n;
  logic           hold_vld, hold_vld_n;
  logic [7:0]     hold_data, hold_data_n;
  logic           hold_first, hold_first_n;

  logic           push, push_eop;
  logic           err_set;
  logic [1:0]     code;
  logic [1:0]     err_code;
  logic           err;

  logic           out_vld;
  logic [7:0]     out_data;
  logic           out_sop, out_eop;

  usb_nrzi_unstuff #(
    .STUFF_LEN(STUFF_LEN)
  ) u_nrzi (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (rx_bit_en),
    .dp       (rx_dp),
    .dm       (rx_dm),
    .in_pkt   (state == DATA),
    .bit_vld  (bit_vld),
    .bit_val  (bit_val),
    .se0      (se0),
    .stuff_err(stuff_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= '1;
      sr         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      se0_cnt    <= '0;
      hold_vld   <= 1'b0;
      hold_data  <= '0;
      hold_first <= 1'b0;
    end else begin
      state      <= state_n;
      win        <= win_n;
      sr         <= sr_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      se0_cnt    <= se0_cnt_n;
      hold_vld   <= hold_vld_n;
      hold_data  <= hold_data_n;
      hold_first <= hold_first_n;
    end
  end

  always_comb begin
    state_n      = state;
    win_n        = win;
    sr_n         = sr;
    bit_cnt_n    = bit_cnt;
    byte_cnt_n   = byte_cnt;
    se0_cnt_n    = se0_cnt;
    hold_vld_n   = hold_vld;
    hold_data_n  = hold_data;
    hold_first_n = hold_first;
    push         = 1'b0;
    push_eop     = 1'b0;
    err_set      = 1'b0;
    code         = ERR_NONE;
    unique case (state)
      IDLE: begin
        if (bit_vld) begin
          win_n = {bit_val, win[7:1]};
          if (win_n == SYNC_PAT) begin
            state_n    = DATA;
            win_n      = '1;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
            se0_cnt_n  = '0;
            hold_vld_n = 1'b0;
          end
        end
      end
      DATA: begin
        if (rx_bit_en && !se0) se0_cnt_n = '0;
        if (stuff_err) begin
          err_set = 1'b1;
          code    = ERR_STUFF;
        end else if (bit_vld) begin
          sr_n      = {bit_val, sr[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt_n   = byte_cnt + 1'b1;
            push         = hold_vld;
            hold_vld_n   = 1'b1;
            hold_data_n  = sr_n;
            hold_first_n = (byte_cnt == '0);
            if (byte_cnt_n > BCW'(MAX_BYTES)) begin
              err_set = 1'b1;
              code    = ERR_BABBLE;
            end
          end
        end else if (se0) begin
          if (se0_cnt == SCW'(EOP_SE0_BITS - 1)) begin
            if (bit_cnt != '0) begin
              err_set = 1'b1;
              code    = ERR_ALIGN;
            end else begin
              push       = hold_vld;
              push_eop   = 1'b1;
              hold_vld_n = 1'b0;
              state_n    = EOP_WAIT;
            end
          end else begin
            se0_cnt_n = se0_cnt + 1'b1;
          end
        end
      end
      EOP_WAIT: begin
        if (rx_bit_en && rx_dp && !rx_dm) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // pushing over an unaccepted byte is an overflow
    if (push && out_vld && !rx_lp_ready) begin
      err_set = 1'b1;
      code    = ERR_BABBLE;
    end
    if (err_set) begin
      push       = 1'b0;
      hold_vld_n = 1'b0;
      se0_cnt_n  = '0;
      state_n    = EOP_WAIT;
    end
  end

  // push carries the old held byte; a same-cycle accept frees the slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err <= err_set;
      if (err_set) err_code <= code;
      if (push) begin
        out_vld  <= 1'b1;
        out_data <= hold_data;
        out_sop  <= hold_first;
        out_eop  <= push_eop;
      end else if (out_vld && rx_lp_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt <= '0;
    else if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign rx_err_cnt = err_cnt;
`else
  assign rx_err_cnt = 8'h00;
`endif

  assign rx_lp_valid = out_vld;
  assign rx_lp_data  = out_data;
  assign rx_lp_sop   = out_sop;
  assign rx_lp_eop   = out_eop;
  assign rx_active   = (state != IDLE);
  assign rx_err      = err;
  assign rx_err_code = err_code;

endmodule

// File: tb/tb_usb_rx_deser.sv
// Scoreboard testbench for usb_rx_deser.
// Stimulus queues expectations; a negedge monitor compares.
module tb_usb_rx_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_bit_en = 1'b0;
  logic       rx_dp = 1'b1;
  logic       rx_dm = 1'b0;
  logic       rx_lp_ready = 1'b1;
  logic       rx_lp_sop, rx_lp_eop, rx_lp_valid;
  logic [7:0] rx_lp_data;
  logic       rx_active, rx_err;
  logic [1:0] rx_err_code;
  logic [7:0] rx_err_cnt;

  usb_rx_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_bit_en  (rx_bit_en),
    .rx_dp      (rx_dp),
    .rx_dm      (rx_dm),
    .rx_lp_sop  (rx_lp_sop),
    .rx_lp_eop  (rx_lp_eop),
    .rx_lp_valid(rx_lp_valid),
    .rx_lp_ready(rx_lp_ready),
    .rx_lp_data (rx_lp_data),
    .rx_active  (rx_active),
    .rx_err     (rx_err),
    .rx_err_code(rx_err_code),
    .rx_err_cnt (rx_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic       e;
    logic [7:0] d;
  } ob_t;

  typedef struct packed {
    logic [2:0] k;
    logic [7:0] v;
  } pr_t;

  ob_t        exp_q[$];
  logic [1:0] err_q[$];
  pr_t        prb_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;
  bit lvl = 1'b1;
  int ones = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic dp, input logic dm);
    rx_dp = dp;
    rx_dm = dm;
    rx_bit_en = 1'b1;
    tick();
    rx_bit_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic nrzi(input bit b);
    if (!b) lvl = ~lvl;
    line(lvl, ~lvl);
  endtask

  task automatic dbit(input bit b, input bit stf);
    nrzi(b);
    if (b) ones++;
    else ones = 0;
    if (stf && ones == 6) begin
      nrzi(1'b0);
      ones = 0;
    end
  endtask

  task automatic sync();
    for (int i = 0; i < 8; i++) nrzi(i == 7);
    ones = 0;
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) dbit(b[i], 1'b1);
  endtask

  task automatic eop();
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    lvl = 1'b1;
    ones = 0;
    line(1'b1, 1'b0);
  endtask

  task automatic expb(input logic [7:0] d, input logic s, input logic e);
    ob_t o;
    o.s = s;
    o.e = e;
    o.d = d;
    exp_q.push_back(o);
  endtask

  task automatic probe(input logic [2:0] k, input logic [7:0] v);
    pr_t p;
    p.k = k;
    p.v = v;
    prb_q.push_back(p);
  endtask

  // kinds: 0 active, 1 err_cnt, 2 valid, 3 data, 4 code, 5 err, 6 sop, 7 eop
  function automatic logic [7:0] probe_val(input logic [2:0] k);
    case (k)
      3'd0:    return {7'd0, rx_active};
      3'd1:    return rx_err_cnt;
      3'd2:    return {7'd0, rx_lp_valid};
      3'd3:    return rx_lp_data;
      3'd4:    return {6'd0, rx_err_code};
      3'd5:    return {7'd0, rx_err};
      3'd6:    return {7'd0, rx_lp_sop};
      default: return {7'd0, rx_lp_eop};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [9:0] act,
                     input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  pr_t  mp;
  ob_t  me;
  ob_t  held;
  logic hold_prev = 1'b0;
  logic [1:0] mc;

  always @(negedge clk) begin
    while (prb_q.size() > 0) begin
      mp = prb_q.pop_front();
      chk($sformatf("probe%0d", mp.k), {2'b0, probe_val(mp.k)},
          {2'b0, mp.v});
    end
    if (hold_prev) begin
      chk("hold_valid", {9'd0, rx_lp_valid}, 10'd1);
      chk("hold_stable", {rx_lp_sop, rx_lp_eop, rx_lp_data}, held);
    end
    if (rx_lp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {rx_lp_sop, rx_lp_eop, rx_lp_data}, 10'h3FF);
      end else begin
        me = exp_q[0];
        chk("byte", {rx_lp_sop, rx_lp_eop, rx_lp_data}, me);
        if (rx_lp_ready) exp_q.delete(0);
      end
    end
    hold_prev = rx_lp_valid && !rx_lp_ready;
    held = {rx_lp_sop, rx_lp_eop, rx_lp_data};
    if (rx_err) begin
      if (err_q.size() == 0) begin
        chk("unexpected_err", {8'd0, rx_err_code}, 10'h3FF);
      end else begin
        mc = err_q.pop_front();
        chk("err_code", {8'd0, rx_err_code}, {8'd0, mc});
      end
    end
    if (done) begin
      chk("bytes_left", 10'(exp_q.size()), 10'd0);
      chk("errs_left", 10'(err_q.size()), 10'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) probe(3'(k), 8'h00);
    repeat (4) line(1'b1, 1'b0);

    // three-byte packet
    expb(8'h69, 1'b1, 1'b0);
    expb(8'h85, 1'b0, 1'b0);
    expb(8'h38, 1'b0, 1'b1);
    sync();
    probe(3'd0, 8'h01);
    sbyte(8'h69);
    sbyte(8'h85);
    sbyte(8'h38);
    eop();
    probe(3'd0, 8'h00);
    repeat (2) line(1'b1, 1'b0);

    // stuffed 0xFF then 0x00
    expb(8'hFF, 1'b1, 1'b0);
    expb(8'h00, 1'b0, 1'b1);
    sync();
    sbyte(8'hFF);
    sbyte(8'h00);
    eop();
    repeat (2) line(1'b1, 1'b0);

    // seven ones: stuff error
    err_q.push_back(2'b01);
    sync();
    for (int i = 0; i < 7; i++) dbit(1'b1, 1'b0);
    probe(3'd4, 8'h01);
    probe(3'd0, 8'h01);
    eop();
    probe(3'd0, 8'h00);
    repeat (2) line(1'b1, 1'b0);

    // 0x2D plus four bits: alignment error
    err_q.push_back(2'b10);
    sync();
    sbyte(8'h2D);
    for (int i = 0; i < 4; i++) dbit(i[0], 1'b1);
    eop();
    probe(3'd4, 8'h02);
    probe(3'd0, 8'h00);
    repeat (2) line(1'b1, 1'b0);

    // 0xD2 with consumer stalled
    rx_lp_ready = 1'b0;
    expb(8'hD2, 1'b1, 1'b1);
    sync();
    sbyte(8'hD2);
    eop();
    repeat (5) tick();
    rx_lp_ready = 1'b1;
    repeat (3) tick();
    repeat (2) line(1'b1, 1'b0);

    // reset mid-byte, then 0xA5
    sync();
    for (int i = 0; i < 4; i++) dbit(i[0], 1'b1);
    rst_n = 1'b0;
    repeat (2) tick();
    rx_dp = 1'b1;
    rx_dm = 1'b0;
    lvl = 1'b1;
    ones = 0;
    rst_n = 1'b1;
    tick();
    probe(3'd0, 8'h00);
    probe(3'd2, 8'h00);
    repeat (2) line(1'b1, 1'b0);
    expb(8'hA5, 1'b1, 1'b1);
    sync();
    sbyte(8'hA5);
    eop();
    probe(3'd1, 8'h00);
    probe(3'd0, 8'h00);

    repeat (4) tick();
    done = 1'b1;
  end

endmodule
